// File: rtl/ocp2axi_cpl.sv
// OCP read-response to PCIe Completion TLP converter (AXI4-Stream master).
// Optional build macro OCP2AXI_STATS_EN adds cpl_count/err_count outputs.
module ocp2axi_cpl #(
    parameter int          FIFO_WDTH    = 32,
    parameter int          KEEP_WDTH    = 4,
    parameter int          BUF_DEPTH    = 8,
    parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpl_req_valid,
    output logic                 cpl_req_ready,
    input  logic [15:0]          cpl_req_id,
    input  logic [7:0]           cpl_tag,
    input  logic [9:0]           cpl_len,
    input  logic [11:0]          cpl_byte_cnt,
    input  logic [6:0]           cpl_lower_addr,
    input  logic [1:0]           resp,
    input  logic [FIFO_WDTH-1:0] resp_data,
    output logic                 resp_accept,
    output logic                 s_axis_tvalid,
    input  logic                 s_axis_tready,
    output logic [FIFO_WDTH-1:0] s_axis_tdata,
    output logic [KEEP_WDTH-1:0] s_axis_tkeep,
    output logic                 s_axis_tlast,
`ifdef OCP2AXI_STATS_EN
    output logic [15:0]          cpl_count,
    output logic [15:0]          err_count,
`endif
    output logic                 resp_overflow
);

    localparam int AW = $clog2(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HDR0,
        S_HDR1,
        S_HDR2,
        S_DATA,
        S_DROP
    } state_t;

    state_t state_q, state_d;

    logic                 init_q;
    logic [15:0]          req_id_q, req_id_d;
    logic [7:0]           tag_q, tag_d;
    logic [9:0]           len_q, len_d;
    logic [11:0]          bc_q, bc_d;
    logic [6:0]           la_q, la_d;
    logic                 err_q, err_d;
    logic [10:0]          rem_q, rem_d;
    logic                 tvalid_q, tvalid_d;
    logic [FIFO_WDTH-1:0] tdata_q, tdata_d;
    logic                 tlast_q, tlast_d;
    logic                 ovf_q;

    logic [AW:0]          wptr_q, rptr_q;
    logic [FIFO_WDTH:0]   mem_q [BUF_DEPTH];

    logic                 full, empty;
    logic                 push, pop;
    logic [FIFO_WDTH:0]   head;
    logic                 head_err;
    logic [10:0]          len_eff;
    logic                 data_load;
    logic [10:0]          rem_cur;
    logic [31:0]          dw0_ok, dw0_err, dw1, dw2;
    logic [2:0]           status;

    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

    assign resp_accept = !full;
    assign push        = (resp != 2'b00) && resp_accept;

    assign head     = mem_q[rptr_q[AW-1:0]];
    assign head_err = head[FIFO_WDTH];

    assign len_eff = (len_q == 10'd0) ? 11'd1024 : {1'b0, len_q};

    // Header dwords built from the latched descriptor
    assign status  = err_q ? 3'b001 : 3'b000;
    assign dw0_ok  = {3'b010, 5'b01010, 1'b0, 3'b000, 4'b0000,
                      1'b0, 1'b0, 2'b00, 2'b00, len_q};
    assign dw0_err = {3'b000, 5'b01010, 1'b0, 3'b000, 4'b0000,
                      1'b0, 1'b0, 2'b00, 2'b00, 10'd0};
    assign dw1     = {COMPLETER_ID, status, 1'b0, bc_q};
    assign dw2     = {req_id_q, tag_q, 1'b0, la_q};

    assign cpl_req_ready = init_q && (state_q == S_IDLE);
    assign s_axis_tvalid = tvalid_q;
    assign s_axis_tdata  = tdata_q;
    assign s_axis_tlast  = tlast_q;
    assign s_axis_tkeep  = tvalid_q ? {KEEP_WDTH{1'b1}} : {KEEP_WDTH{1'b0}};
    assign resp_overflow = ovf_q;

    // Response buffer storage (contents qualified by the pointers)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {resp[1], resp_data};
        end
    end

    // Buffer pointers and sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if ((resp != 2'b00) && !resp_accept) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FSM state, descriptor and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            init_q   <= 1'b0;
            req_id_q <= '0;
            tag_q    <= '0;
            len_q    <= '0;
            bc_q     <= '0;
            la_q     <= '0;
            err_q    <= 1'b0;
            rem_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            init_q   <= 1'b1;
            req_id_q <= req_id_d;
            tag_q    <= tag_d;
            len_q    <= len_d;
            bc_q     <= bc_d;
            la_q     <= la_d;
            err_q    <= err_d;
            rem_q    <= rem_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
        end
    end

    // Next-state, buffer pop and output-register loading
    always_comb begin
        state_d   = state_q;
        req_id_d  = req_id_q;
        tag_d     = tag_q;
        len_d     = len_q;
        bc_d      = bc_q;
        la_d      = la_q;
        err_d     = err_q;
        rem_d     = rem_q;
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        pop       = 1'b0;
        data_load = 1'b0;
        rem_cur   = rem_q;

        case (state_q)
            S_IDLE: begin
                if (cpl_req_valid && cpl_req_ready) begin
                    req_id_d = cpl_req_id;
                    tag_d    = cpl_tag;
                    len_d    = cpl_len;
                    bc_d     = cpl_byte_cnt;
                    la_d     = cpl_lower_addr;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!empty) begin
                    err_d    = head_err;
                    tvalid_d = 1'b1;
                    tdata_d  = head_err ? dw0_err : dw0_ok;
                    tlast_d  = 1'b0;
                    state_d  = S_HDR0;
                end
            end
            S_HDR0: begin
                if (s_axis_tready) begin
                    tdata_d = dw1;
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (s_axis_tready) begin
                    tdata_d = dw2;
                    tlast_d = err_q;
                    state_d = S_HDR2;
                end
            end
            S_HDR2: begin
                if (s_axis_tready) begin
                    rem_d = len_eff;
                    if (err_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = S_DROP;
                    end else begin
                        rem_cur   = len_eff;
                        data_load = 1'b1;
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!tvalid_q || s_axis_tready) begin
                    if (tvalid_q && tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        data_load = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (!empty) begin
                    pop   = 1'b1;
                    rem_d = rem_q - 11'd1;
                    if (rem_q == 11'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (data_load) begin
            if ((rem_cur != 11'd0) && !empty) begin
                pop      = 1'b1;
                tvalid_d = 1'b1;
                tdata_d  = head[FIFO_WDTH-1:0];
                tlast_d  = (rem_cur == 11'd1);
                rem_d    = rem_cur - 11'd1;
            end else begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        end
    end

`ifdef OCP2AXI_STATS_EN
    // Completion and error-word counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpl_count <= '0;
            err_count <= '0;
        end else begin
            if (tvalid_q && s_axis_tready && tlast_q) begin
                cpl_count <= cpl_count + 16'd1;
            end
            if (push && resp[1]) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ocp2axi_cpl.sv
// Scoreboard bench for ocp2axi_cpl.
// Stimulus drives at posedge+1; the monitor samples at negedge.
module tb_ocp2axi_cpl;

    logic        clk;
    logic        reset;
    logic        cpl_req_valid;
    logic        cpl_req_ready;
    logic [15:0] cpl_req_id;
    logic [7:0]  cpl_tag;
    logic [9:0]  cpl_len;
    logic [11:0] cpl_byte_cnt;
    logic [6:0]  cpl_lower_addr;
    logic [1:0]  resp;
    logic [31:0] resp_data;
    logic        resp_accept;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        resp_overflow;
`ifdef OCP2AXI_STATS_EN
    logic [15:0] cpl_count;
    logic [15:0] err_count;
`endif

    ocp2axi_cpl dut (
        .clk            (clk),
        .reset          (reset),
        .cpl_req_valid  (cpl_req_valid),
        .cpl_req_ready  (cpl_req_ready),
        .cpl_req_id     (cpl_req_id),
        .cpl_tag        (cpl_tag),
        .cpl_len        (cpl_len),
        .cpl_byte_cnt   (cpl_byte_cnt),
        .cpl_lower_addr (cpl_lower_addr),
        .resp           (resp),
        .resp_data      (resp_data),
        .resp_accept    (resp_accept),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
`ifdef OCP2AXI_STATS_EN
        .cpl_count      (cpl_count),
        .err_count      (err_count),
`endif
        .resp_overflow  (resp_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    logic [32:0] exp_q[$];
    int          tlast_cnt = 0;
    int          run_len = 0;
    int          last_run = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_dw(input logic tl, input logic [31:0] d);
        exp_q.push_back({tl, d});
    endtask

    // Monitor: compares every accepted beat and checks hold-while-stalled
    always @(negedge clk) begin
        logic [32:0] e;
        if (!reset) begin
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(s_axis_tvalid && s_axis_tdata == prev_data &&
                      s_axis_tlast == prev_last)) begin
                    fails++;
                    $display("FAIL hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             s_axis_tvalid, s_axis_tdata, s_axis_tlast,
                             prev_data, prev_last);
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat: got unexpected %h expected none",
                             s_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (s_axis_tdata !== e[31:0] || s_axis_tlast !== e[32] ||
                        s_axis_tkeep !== 4'hF) begin
                        fails++;
                        $display("FAIL beat: got d=%h l=%b k=%h expected d=%h l=%b k=f",
                                 s_axis_tdata, s_axis_tlast, s_axis_tkeep,
                                 e[31:0], e[32]);
                    end
                end
                run_len++;
                if (s_axis_tlast) begin
                    tlast_cnt++;
                    last_run = run_len;
                end
            end else begin
                run_len = 0;
            end
            prev_stall = s_axis_tvalid && !s_axis_tready;
            prev_data  = s_axis_tdata;
            prev_last  = s_axis_tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [15:0] id, input logic [7:0] tag,
                             input logic [9:0] len, input logic [11:0] bc,
                             input logic [6:0] la);
        int n = 0;
        cpl_req_id     = id;
        cpl_tag        = tag;
        cpl_len        = len;
        cpl_byte_cnt   = bc;
        cpl_lower_addr = la;
        cpl_req_valid  = 1'b1;
        while (!cpl_req_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!cpl_req_ready) begin
            checks++;
            fails++;
            $display("FAIL desc_timeout: got ready=0 expected 1");
        end
        tick();
        cpl_req_valid = 1'b0;
    endtask

    task automatic send_word(input logic [1:0] r, input logic [31:0] d);
        int n = 0;
        while (!resp_accept && n < 2000) begin
            tick();
            n++;
        end
        if (!resp_accept) begin
            checks++;
            fails++;
            $display("FAIL word_timeout: got accept=0 expected 1");
        end
        resp      = r;
        resp_data = d;
        tick();
        resp = 2'b00;
    endtask

    task automatic wait_last(input string name, input int max);
        int start = tlast_cnt;
        int n = 0;
        while (tlast_cnt == start && n < max) begin
            tick();
            n++;
        end
        if (tlast_cnt == start) begin
            checks++;
            fails++;
            $display("FAIL %s: got no tlast expected tlast within %0d", name, max);
        end
    endtask

    initial begin
        reset          = 1'b0;
        cpl_req_valid  = 1'b0;
        cpl_req_id     = '0;
        cpl_tag        = '0;
        cpl_len        = '0;
        cpl_byte_cnt   = '0;
        cpl_lower_addr = '0;
        resp           = 2'b00;
        resp_data      = '0;
        s_axis_tready  = 1'b1;

        // Reset state
        #2;
        chk("rst_tvalid", {31'd0, s_axis_tvalid}, 32'd0);
        chk("rst_tdata", s_axis_tdata, 32'd0);
        chk("rst_tkeep", {28'd0, s_axis_tkeep}, 32'd0);
        chk("rst_tlast", {31'd0, s_axis_tlast}, 32'd0);
        chk("rst_ovf", {31'd0, resp_overflow}, 32'd0);
        chk("rst_accept", {31'd0, resp_accept}, 32'd1);
        chk("rst_ready", {31'd0, cpl_req_ready}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("ready_pre_clk", {31'd0, cpl_req_ready}, 32'd0);
        tick();
        chk("ready_post_clk", {31'd0, cpl_req_ready}, 32'd1);

        // 1: basic CplD, tready=1, back-to-back beats
        expect_dw(1'b0, 32'h4A00_0003);
        expect_dw(1'b0, 32'h0100_000C);
        expect_dw(1'b0, 32'h0001_0500);
        expect_dw(1'b0, 32'h0000_00A1);
        expect_dw(1'b0, 32'h0000_00A2);
        expect_dw(1'b1, 32'h0000_00A3);
        send_desc(16'h0001, 8'h05, 10'd3, 12'd12, 7'd0);
        send_word(2'b01, 32'h0000_00A1);
        send_word(2'b01, 32'h0000_00A2);
        send_word(2'b01, 32'h0000_00A3);
        wait_last("t1_last", 100);
        chk("t1_consecutive", last_run, 32'd6);

        // 2: same TLP with tready toggling every clock
        s_axis_tready = 1'b0;
        expect_dw(1'b0, 32'h4A00_0003);
        expect_dw(1'b0, 32'h0100_000C);
        expect_dw(1'b0, 32'h0001_0500);
        expect_dw(1'b0, 32'h0000_00A1);
        expect_dw(1'b0, 32'h0000_00A2);
        expect_dw(1'b1, 32'h0000_00A3);
        send_desc(16'h0001, 8'h05, 10'd3, 12'd12, 7'd0);
        send_word(2'b01, 32'h0000_00A1);
        send_word(2'b01, 32'h0000_00A2);
        send_word(2'b01, 32'h0000_00A3);
        begin
            int start = tlast_cnt;
            int n = 0;
            while (tlast_cnt == start && n < 100) begin
                s_axis_tready = ~s_axis_tready;
                tick();
                n++;
            end
            if (tlast_cnt == start) begin
                checks++;
                fails++;
                $display("FAIL t2_last: got no tlast expected tlast");
            end
        end
        s_axis_tready = 1'b1;

        // 3: ERR head -> 3DW Cpl with UR status, remaining word dropped
        expect_dw(1'b0, 32'h0A00_0000);
        expect_dw(1'b0, 32'h0100_2008);
        expect_dw(1'b1, 32'h0002_0710);
        send_desc(16'h0002, 8'h07, 10'd2, 12'd8, 7'h10);
        send_word(2'b11, 32'h0000_00EE);
        send_word(2'b01, 32'h0000_00BB);
        wait_last("t3_last", 100);
        repeat (4) tick();
        chk("t3_idle_ready", {31'd0, cpl_req_ready}, 32'd1);
        chk("t3_accept", {31'd0, resp_accept}, 32'd1);
`ifdef OCP2AXI_STATS_EN
        chk("stats_cpl", {16'd0, cpl_count}, 32'd3);
        chk("stats_err", {16'd0, err_count}, 32'd1);
`endif

        // 4: fill buffer with tready=0, force overflow word
        s_axis_tready = 1'b0;
        expect_dw(1'b0, 32'h4A00_0008);
        expect_dw(1'b0, 32'h0100_0020);
        expect_dw(1'b0, 32'h0003_0900);
        for (int i = 0; i < 8; i++) begin
            expect_dw(i == 7, 32'h0000_00C0 + i);
        end
        send_desc(16'h0003, 8'h09, 10'd8, 12'd32, 7'd0);
        for (int i = 0; i < 8; i++) begin
            send_word(2'b01, 32'h0000_00C0 + i);
        end
        chk("t4_full_accept", {31'd0, resp_accept}, 32'd0);
        chk("t4_no_ovf_yet", {31'd0, resp_overflow}, 32'd0);
        resp      = 2'b01;
        resp_data = 32'h0000_DEAD;
        tick();
        resp = 2'b00;
        chk("t4_ovf", {31'd0, resp_overflow}, 32'd1);
        s_axis_tready = 1'b1;
        wait_last("t4_last", 100);
        tick();
        chk("t4_ovf_sticky", {31'd0, resp_overflow}, 32'd1);
        chk("t4_accept_back", {31'd0, resp_accept}, 32'd1);

        // 5: len=0 -> 1024 data words, pointer wrap
        expect_dw(1'b0, 32'h4A00_0000);
        expect_dw(1'b0, 32'h0100_0000);
        expect_dw(1'b0, 32'h0004_0B00);
        for (int i = 0; i < 1024; i++) begin
            expect_dw(i == 1023, 32'h5000_0000 + i);
        end
        send_desc(16'h0004, 8'h0B, 10'd0, 12'd0, 7'd0);
        begin
            int i = 0;
            int n = 0;
            while (i < 1024 && n < 5000) begin
                if (resp_accept) begin
                    resp      = 2'b01;
                    resp_data = 32'h5000_0000 + i;
                    i++;
                end else begin
                    resp = 2'b00;
                end
                tick();
                n++;
            end
            resp = 2'b00;
            if (i < 1024) begin
                checks++;
                fails++;
                $display("FAIL t5_feed: got %0d words expected 1024", i);
            end
        end
        wait_last("t5_last", 200);
        chk("t5_drained", exp_q.size(), 32'd0);

        // 6: reset during 2nd data beat, then a fresh len=1 completion
        s_axis_tready = 1'b0;
        expect_dw(1'b0, 32'h4A00_0003);
        expect_dw(1'b0, 32'h0100_000C);
        expect_dw(1'b0, 32'h0005_0C00);
        expect_dw(1'b0, 32'h0000_0071);
        expect_dw(1'b0, 32'h0000_0072);
        expect_dw(1'b1, 32'h0000_0073);
        send_desc(16'h0005, 8'h0C, 10'd3, 12'd12, 7'd0);
        send_word(2'b01, 32'h0000_0071);
        send_word(2'b01, 32'h0000_0072);
        send_word(2'b01, 32'h0000_0073);
        begin
            int n = 0;
            while (!s_axis_tvalid && n < 100) begin
                tick();
                n++;
            end
        end
        s_axis_tready = 1'b1;
        repeat (4) tick();
        chk("t6_beats_done", exp_q.size(), 32'd2);
        chk("t6_pre_rst_tvalid", {31'd0, s_axis_tvalid}, 32'd1);
        reset         = 1'b0;
        s_axis_tready = 1'b0;
        #1;
        chk("t6_rst_tvalid", {31'd0, s_axis_tvalid}, 32'd0);
        chk("t6_rst_tdata", s_axis_tdata, 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        #1;
        chk("t6_ready_pre_clk", {31'd0, cpl_req_ready}, 32'd0);
        tick();
        chk("t6_ready", {31'd0, cpl_req_ready}, 32'd1);
        chk("t6_ovf_clear", {31'd0, resp_overflow}, 32'd0);
`ifdef OCP2AXI_STATS_EN
        chk("t6_stats_cpl", {16'd0, cpl_count}, 32'd0);
`endif
        s_axis_tready = 1'b1;
        expect_dw(1'b0, 32'h4A00_0001);
        expect_dw(1'b0, 32'h0100_0004);
        expect_dw(1'b0, 32'h0006_0D04);
        expect_dw(1'b1, 32'h6666_0001);
        send_desc(16'h0006, 8'h0D, 10'd1, 12'd4, 7'h04);
        send_word(2'b01, 32'h6666_0001);
        wait_last("t6_last", 100);
        repeat (3) tick();
        chk("t6_drained", exp_q.size(), 32'd0);
        chk("t6_idle_tvalid", {31'd0, s_axis_tvalid}, 32'd0);
`ifdef OCP2AXI_STATS_EN
        chk("t6_stats_cpl2", {16'd0, cpl_count}, 32'd1);
        chk("t6_stats_err", {16'd0, err_count}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
